// File: rtl/trend_signal_gen_if.sv
// trend_signal_gen_if: tagged price stream in, registered price plus trend signals out.
interface trend_signal_gen_if;
   logic        valid_in;
   logic [15:0] data_in;
   logic        valid_out;
   logic [15:0] data_out;
   logic        EMA_buy;
   logic        EMA_sell;
   logic        Momentum_buy;
   logic        Momentum_sell;
   modport master(
      output valid_in, data_in,
      input  valid_out, data_out, EMA_buy, EMA_sell, Momentum_buy, Momentum_sell
   );
   modport slave(
      input  valid_in, data_in,
      output valid_out, data_out, EMA_buy, EMA_sell, Momentum_buy, Momentum_sell
   );
endinterface

// File: rtl/trend_signal_gen.sv
// trend_signal_gen: per-stock EMA and momentum trend signals for 4 stocks, 1-cycle latency.
// Optional TREND_EMA_GATE_EN: momentum signals additionally require agreement with the EMA.
module trend_signal_gen #(
   parameter int DEPTH      = 8,
   parameter int EMA_SHIFT  = 3,
   parameter int EMA_MARGIN = 4,
   parameter int MOM_THRESH = 16
) (
   input logic               clk,
   input logic               rst,
   trend_signal_gen_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(DEPTH + 1);
   localparam logic signed [14:0] TH = 15'(MOM_THRESH);
   logic [17:0]          ema [4];
   logic [3:0]           ema_valid;
   logic [FW-1:0]        fill [4];
   logic [AW-1:0]        wptr [4];
   logic [13:0]          ring [4][DEPTH];
   logic [1:0]           s;
   logic [13:0]          p;
   logic [13:0]          ema_int;
   logic [13:0]          old;
   logic                 first;
   logic                 warm;
   logic                 ema_buy;
   logic                 ema_sell;
   logic                 mom_buy;
   logic                 mom_sell;
   logic                 gate_buy;
   logic                 gate_sell;
   logic signed [18:0]   delta;
   logic signed [18:0]   step;
   logic signed [14:0]   diff;
   logic [17:0]          ema_next;
   always_comb begin
      s        = bus.data_in[15:14];
      p        = bus.data_in[13:0];
      ema_int  = ema[s][17:4];
      first    = !ema_valid[s];
      old      = ring[s][wptr[s]];
      warm     = fill[s] == FW'(DEPTH);
      // floor shift keeps the EMA inside 0..262128 in both directions
      delta    = $signed({1'b0, p, 4'b0}) - $signed({1'b0, ema[s]});
      step     = delta >>> EMA_SHIFT;
      ema_next = first ? {p, 4'b0} : 18'($signed({1'b0, ema[s]}) + step);
      ema_buy  = !first && ({2'b0, p} > {2'b0, ema_int} + 16'(EMA_MARGIN));
      ema_sell = !first && ({2'b0, p} + 16'(EMA_MARGIN) < {2'b0, ema_int});
      diff     = $signed({1'b0, p}) - $signed({1'b0, old});
`ifdef TREND_EMA_GATE_EN
      gate_buy  = p >= ema_int;
      gate_sell = p <= ema_int;
`else
      gate_buy  = 1'b1;
      gate_sell = 1'b1;
`endif
      mom_buy  = warm && gate_buy && (diff > TH);
      mom_sell = warm && gate_sell && (diff < -TH);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            ema[i]  <= '0;
            fill[i] <= '0;
            wptr[i] <= '0;
         end
         ema_valid <= '0;
      end else if (bus.valid_in) begin
         ema[s]       <= ema_next;
         ema_valid[s] <= 1'b1;
         fill[s]      <= warm ? fill[s] : fill[s] + 1'b1;
         wptr[s]      <= wptr[s] + 1'b1;
      end
   end
   // history contents are only read once fill says they are valid, so no reset
   always_ff @(posedge clk) begin
      if (bus.valid_in) ring[s][wptr[s]] <= p;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.valid_out     <= 1'b0;
         bus.data_out      <= '0;
         bus.EMA_buy       <= 1'b0;
         bus.EMA_sell      <= 1'b0;
         bus.Momentum_buy  <= 1'b0;
         bus.Momentum_sell <= 1'b0;
      end else begin
         bus.valid_out     <= bus.valid_in;
         bus.data_out      <= bus.valid_in ? bus.data_in : bus.data_out;
         bus.EMA_buy       <= bus.valid_in && ema_buy;
         bus.EMA_sell      <= bus.valid_in && ema_sell;
         bus.Momentum_buy  <= bus.valid_in && mom_buy;
         bus.Momentum_sell <= bus.valid_in && mom_sell;
      end
   end
endmodule

// File: tb/tb_trend_signal_gen.sv
// tb_trend_signal_gen: directed vectors checked against a per-stock arithmetic model every cycle.
module tb_trend_signal_gen;
   localparam int DEPTH = 8, EMA_SHIFT = 3, EMA_MARGIN = 4, MOM_THRESH = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   trend_signal_gen_if bus();
   trend_signal_gen #(
      .DEPTH(DEPTH), .EMA_SHIFT(EMA_SHIFT), .EMA_MARGIN(EMA_MARGIN), .MOM_THRESH(MOM_THRESH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   int   m_ema [4];
   bit   m_ev [4];
   int   hist [4][$];
   logic pend_v;
   logic [15:0] pend_d;
   logic [3:0]  pend_sig;
   logic        exp_v;
   logic [15:0] exp_d;
   logic [3:0]  exp_sig;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_v   <= 1'b0;
         exp_d   <= '0;
         exp_sig <= '0;
      end else begin
         exp_v   <= pend_v;
         exp_d   <= pend_v ? pend_d : exp_d;
         exp_sig <= pend_v ? pend_sig : 4'b0;
      end
   end
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if ({bus.valid_out, bus.data_out, bus.EMA_buy, bus.EMA_sell, bus.Momentum_buy, bus.Momentum_sell}
             !== {exp_v, exp_d, exp_sig}) begin
            errors++;
            $display("FAIL model t=%0t: got v=%b d=%h sig=%b%b%b%b, want v=%b d=%h sig=%b", $time,
                     bus.valid_out, bus.data_out, bus.EMA_buy, bus.EMA_sell, bus.Momentum_buy,
                     bus.Momentum_sell, exp_v, exp_d, exp_sig);
         end
      end
   end
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask
   function automatic logic [15:0] w(input int s, input int p);
      return 16'((s << 14) | p);
   endfunction
   task automatic step(input bit v, input logic [15:0] d);
      int  s, p, ei, dd, den, diff;
      bit  eb, es, mb, ms;
      @(negedge clk);
      bus.valid_in = v;
      bus.data_in  = d;
      pend_v       = v;
      pend_d       = d;
      pend_sig     = '0;
      if (v) begin
         s   = int'(d[15:14]);
         p   = int'(d[13:0]);
         ei  = m_ema[s] / 16;
         den = 1 << EMA_SHIFT;
         eb  = 0;
         es  = 0;
         if (!m_ev[s]) begin
            m_ema[s] = p * 16;
            m_ev[s]  = 1;
         end else begin
            eb = p > ei + EMA_MARGIN;
            es = p + EMA_MARGIN < ei;
            dd = p * 16 - m_ema[s];
            m_ema[s] += (dd >= 0) ? dd / den : -((-dd + den - 1) / den);
         end
         mb = 0;
         ms = 0;
         if (hist[s].size() == DEPTH) begin
            diff = p - hist[s][0];
            mb   = diff > MOM_THRESH;
            ms   = diff < -MOM_THRESH;
`ifdef TREND_EMA_GATE_EN
            mb = mb && (p >= ei);
            ms = ms && (p <= ei);
`endif
         end
         hist[s].push_back(p);
         if (hist[s].size() > DEPTH) void'(hist[s].pop_front());
         pend_sig = {eb, es, mb, ms};
      end
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      bus.valid_in = 1'b0;
      pend_v       = 1'b0;
      pend_sig     = '0;
      for (int i = 0; i < 4; i++) begin
         m_ema[i] = 0;
         m_ev[i]  = 0;
         hist[i].delete();
      end
      @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic settle();
      @(posedge clk);
      #1;
   endtask
   initial begin
      bus.valid_in = 1'b0;
      bus.data_in  = '0;
      pend_v       = 1'b0;
      pend_d       = '0;
      pend_sig     = '0;
      do_reset();
      #1;
      chk("reset_outputs", {bus.valid_out, bus.data_out, bus.EMA_buy, bus.EMA_sell,
                            bus.Momentum_buy, bus.Momentum_sell}, 0);
      // first sample and EMA buy
      step(1, w(0, 1000));
      settle();
      chk("first_valid", bus.valid_out, 1);
      chk("first_data", bus.data_out, 16'h03E8);
      chk("first_sigs", {bus.EMA_buy, bus.EMA_sell, bus.Momentum_buy, bus.Momentum_sell}, 0);
      chk("model_ema0_first", m_ema[0], 16000);
      step(1, w(0, 1100));
      settle();
      chk("ema_buy", {bus.EMA_buy, bus.EMA_sell}, 2'b10);
      chk("model_ema0_second", m_ema[0], 16200);
      step(1, w(0, 1012));
      settle();
      chk("ema_inside_margin", {bus.EMA_buy, bus.EMA_sell}, 2'b00);
      step(0, 0);
      settle();
      chk("gap_hold", {bus.valid_out, bus.data_out, bus.EMA_buy, bus.EMA_sell,
                       bus.Momentum_buy, bus.Momentum_sell}, {1'b0, w(0, 1012), 4'b0});
      // momentum warm-up on stock 1
      for (int i = 0; i < 8; i++) begin
         step(1, w(1, 2000));
         settle();
         chk("mom_cold", bus.Momentum_buy, 0);
      end
      step(1, w(1, 2020));
      settle();
      chk("mom_buy", {bus.Momentum_buy, bus.Momentum_sell}, 2'b10);
      step(1, w(1, 1980));
      settle();
      chk("mom_sell", {bus.Momentum_buy, bus.Momentum_sell}, 2'b01);
      step(0, 0);
      do_reset();
      for (int i = 0; i < 8; i++) step(1, w(1, 2000));
      step(1, w(1, 2010));
      settle();
      chk("mom_below_thresh", {bus.Momentum_buy, bus.Momentum_sell}, 2'b00);
      step(0, 0);
      // interleaved stocks 2 and 3
      do_reset();
      step(1, w(2, 5000));
      step(1, w(3, 3000));
      step(1, w(2, 5000));
      settle();
      chk("s2_quiet", {bus.EMA_buy, bus.EMA_sell, bus.Momentum_buy, bus.Momentum_sell}, 0);
      step(1, w(3, 2900));
      settle();
      chk("s3_ema_sell", {bus.EMA_buy, bus.EMA_sell}, 2'b01);
      chk("model_s2_fill", hist[2].size(), 2);
      step(0, 0);
      // full-scale EMA swing
      do_reset();
      step(1, w(0, 16383));
      step(1, w(0, 0));
      settle();
      chk("extreme_ema_sell", bus.EMA_sell, 1);
      chk("model_ema0_extreme", m_ema[0], 229362);
      step(0, 0);
      settle();
      chk("gap_valid", {bus.valid_out, bus.EMA_buy, bus.EMA_sell, bus.Momentum_buy, bus.Momentum_sell}, 0);
      // mid-stream reset with a sample in flight
      for (int i = 0; i < 10; i++) step(1, w(1, 2000 + 10 * i));
      do_reset();
      #1;
      chk("reset_drops_valid", bus.valid_out, 0);
      step(1, w(1, 3000));
      settle();
      chk("post_reset_valid", bus.valid_out, 1);
      chk("post_reset_sigs", {bus.EMA_buy, bus.EMA_sell, bus.Momentum_buy, bus.Momentum_sell}, 0);
      step(0, 0);
      // momentum rise while the EMA sits above the price
      do_reset();
      step(1, w(1, 2000));
      for (int i = 0; i < 7; i++) step(1, w(1, 4000));
      step(1, w(1, 2030));
      settle();
`ifdef TREND_EMA_GATE_EN
      chk("gated_mom_buy", bus.Momentum_buy, 0);
`else
      chk("ungated_mom_buy", bus.Momentum_buy, 1);
`endif
      step(0, 0);
      settle();
      settle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
